wb_trace_fifo: RTL

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

---
 rtl/wb_trace_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_trace_fifo.sv
// GRF write-event trace FIFO: first-word-fall-through queue of {pc, addr, data}.
// Define WB_TRACE_DROP_CNT_EN to build the saturating overflow drop counter.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [4:0]  addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic push_cand;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

  // Writes to $0 never reach the queue and are not counted as drops.
  assign push_cand = in_valid && (in_addr != 5'd0);
  assign pop       = !empty && out_ready;
  assign push      = push_cand && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible while count covers it.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      addr_mem[wr_ptr_q] <= in_addr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    out_valid = !empty;
    out_pc    = '0;
    out_addr  = '0;
    out_data  = '0;
    if (!empty) begin
      out_pc   = pc_mem[rd_ptr_q];
      out_addr = addr_mem[rd_ptr_q];
      out_data = data_mem[rd_ptr_q];
    end
  end

`ifdef WB_TRACE_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = push_cand && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  property p_count_bound;
    @(posedge clk) disable iff (reset) count_q <= (AW+1)'(DEPTH);
  endproperty
  a_count_bound: assert property (p_count_bound);

  property p_full_empty_excl;
    @(posedge clk) !(full && empty);
  endproperty
  a_full_empty_excl: assert property (p_full_empty_excl);

endmodule
